// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus strobe/TI handshake feeding a UART transmitter; never strobes mid-frame.
// Define UART_TX_FEEDER_WDOG_EN to add the start watchdog and the retry output.
`timescale 1ns/1ps

module uart_tx_feeder #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int START_TO = 12000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              tx_ti,
    output logic              tx_wr,
    output logic [7:0]        tx_data,
`ifdef UART_TX_FEEDER_WDOG_EN
    output logic              retry,
`endif
    output logic              busy
);

    if (DEPTH != (1 << ADDR_W) || DEPTH < 2 || DEPTH > 256 || START_TO <= 2 * 5208 || START_TO > 65536)
    begin : g_bad_cfg
        $error("uart_tx_feeder: inconsistent DEPTH/ADDR_W/START_TO");
    end

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT_START, WAIT_DONE} state_t;

    state_t            state, state_nxt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              wr_ok;
    logic              pop;

`ifdef UART_TX_FEEDER_WDOG_EN
    localparam logic [15:0] WD_LAST = 16'(START_TO - 1);
    logic [15:0] wd_cnt;
    logic        wd_fire;
`endif

    // A full FIFO refuses the write even if a pop frees a slot in the same cycle.
    assign wr_ok = wr_en && !full;
    assign busy  = (state != IDLE);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
`ifdef UART_TX_FEEDER_WDOG_EN
        wd_fire   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty && tx_ti) begin
                    pop       = 1'b1;
                    state_nxt = STROBE;
                end
            end
            STROBE: state_nxt = WAIT_START;
            WAIT_START: begin
                // Only the falling TI edge counts here; a high TI is never a new go-ahead.
                if (!tx_ti) begin
                    state_nxt = WAIT_DONE;
                end
`ifdef UART_TX_FEEDER_WDOG_EN
                else if (wd_cnt == WD_LAST) begin
                    state_nxt = STROBE;
                    wd_fire   = 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (tx_ti) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (wr_ok && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (!wr_ok && pop) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_wr    <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state <= state_nxt;
            tx_wr <= (state_nxt == STROBE);
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            empty <= (count_nxt == '0);
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                tx_data <= mem[rd_ptr];
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage carries no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef UART_TX_FEEDER_WDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            retry  <= 1'b0;
        end else begin
            retry <= wd_fire;
            if (state == WAIT_START && state_nxt == WAIT_START) begin
                wd_cnt <= wd_cnt + 16'd1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small TI-driving transmitter model.
`timescale 1ns/1ps

module tb_uart_tx_feeder;

    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int START_TO = 12000;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            ovf_clr;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            tx_ti;
    logic            tx_wr;
    logic [7:0]      tx_data;
    logic            busy;
`ifdef UART_TX_FEEDER_WDOG_EN
    logic            retry;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int base;
    int sent;
    int s_cyc;

    // Transmitter model state (written only by the model process)
    logic       model_en  = 1'b0;
    logic       ti_hold   = 1'b1;
    int         start_dly = 3;
    int         frame_len = 20;
    int         m_state   = 0;
    int         m_cnt     = 0;
    int         rise_cyc  = 0;
    int         rx_n      = 0;
    int         bad_strobe = 0;
    logic [7:0] rx_mem [512];

    uart_tx_feeder #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .START_TO (START_TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_ti    (tx_ti),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
`ifdef UART_TX_FEEDER_WDOG_EN
        .retry    (retry),
`endif
        .busy     (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: on a strobe, hold TI high for start_dly, low for frame_len, then high again.
    always @(negedge clk) begin
        if (!model_en) begin
            m_state <= 0;
            tx_ti   <= ti_hold;
        end else begin
            case (m_state)
                0: begin
                    tx_ti <= 1'b1;
                    if (tx_wr) begin
                        rx_mem[rx_n] <= tx_data;
                        rx_n         <= rx_n + 1;
                        m_state      <= 1;
                        m_cnt        <= start_dly;
                    end
                end
                1: begin
                    if (tx_wr) bad_strobe <= bad_strobe + 1;
                    if (m_cnt == 0) begin
                        tx_ti   <= 1'b0;
                        m_state <= 2;
                        m_cnt   <= frame_len;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: begin
                    if (tx_wr) bad_strobe <= bad_strobe + 1;
                    if (m_cnt == 0) begin
                        tx_ti    <= 1'b1;
                        rise_cyc <= cyc;
                        m_state  <= 0;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_drain(input int n, input string tag);
        int k;
        k = 0;
        while (!((rx_n - base) >= n && !busy && empty) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 4000) chk(tag, 32'd0, 32'd1);
        repeat (30) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_tx_wr", tx_wr, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Single byte with a full-length frame
        start_dly = 3; frame_len = 10 * 5208; model_en = 1'b1;
        @(negedge clk);
        base = rx_n;
        write_byte(8'hA5);
        chk("sb_count1", count, 1);
        chk("sb_no_early_wr", tx_wr, 0);
        @(negedge clk);
        chk("sb_tx_wr", tx_wr, 1);
        chk("sb_tx_data", tx_data, 8'hA5);
        chk("sb_count0", count, 0);
        @(negedge clk);
        chk("sb_wr_pulse", tx_wr, 0);
        chk("sb_busy", busy, 1);
        for (int k = 0; k < 60000; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("sb_busy_fall", cyc - rise_cyc, 1);
        chk("sb_rx_n", rx_n - base, 1);
        chk("sb_rx_data", rx_mem[base], 8'hA5);

        // Burst of five while the transmitter reports busy
        model_en = 1'b0; ti_hold = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("burst_peak", count, 5);
        chk("burst_not_empty", empty, 0);
        base = rx_n; start_dly = 2; frame_len = 20;
        #1 model_en = 1'b1;
        wait_drain(5, "burst_timeout");
        chk("burst_rx_n", rx_n - base, 5);
        for (int i = 0; i < 5; i++) chk("burst_data", rx_mem[base + i], 32'(i + 1));
        chk("burst_no_midframe", bad_strobe, 0);

        // Overflow with TI held low
        model_en = 1'b0; ti_hold = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                chk("ovf_full16", full, 1);
                chk("ovf_count16", count, 16);
                chk("ovf_not_yet", overflow, 0);
            end
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count_hold", count, 16);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);
        chk("ovf_full_stays", full, 1);
        wr_en = 1'b1; wr_data = 8'hEE; ovf_clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; ovf_clr = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        chk("ovf_clr2", overflow, 0);
        base = rx_n; start_dly = 1; frame_len = 6;
        #1 model_en = 1'b1;
        wait_drain(16, "ovf_timeout");
        chk("ovf_rx_n", rx_n - base, 16);
        for (int i = 0; i < 16; i++) chk("ovf_data", rx_mem[base + i], 32'(8'h40 + i));
        chk("ovf_no_midframe", bad_strobe, 0);

        // Wrap: every pop after the first lands together with a write
        model_en = 1'b0; ti_hold = 1'b0;
        repeat (2) @(negedge clk);
        write_byte(8'h80);
        base = rx_n; sent = 1; start_dly = 2; frame_len = 5;
        #1 model_en = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            #1;
            wr_en = 1'b0;
            if (sent < 40 && !busy && !empty && tx_ti) begin
                chk("wrap_count", count, 1);
                wr_en = 1'b1; wr_data = 8'(8'h80 + sent);
                sent++;
            end
            if ((rx_n - base) >= 40 && !busy) break;
        end
        wr_en = 1'b0;
        repeat (20) @(negedge clk);
        chk("wrap_sent", sent, 40);
        chk("wrap_rx_n", rx_n - base, 40);
        for (int i = 0; i < 40; i++) chk("wrap_data", rx_mem[base + i], 32'(8'h80 + i));
        chk("wrap_count0", count, 0);
        chk("wrap_empty", empty, 1);
        chk("wrap_no_midframe", bad_strobe, 0);

`ifdef UART_TX_FEEDER_WDOG_EN
        // Watchdog: TI never falls, so the same byte is strobed again
        model_en = 1'b0; ti_hold = 1'b1;
        repeat (2) @(negedge clk);
        write_byte(8'h3C);
        @(negedge clk);
        chk("wd_first_wr", tx_wr, 1);
        chk("wd_first_retry", retry, 0);
        s_cyc = cyc;
        for (int k = 0; k < START_TO + 20; k++) begin
            @(negedge clk);
            if (tx_wr) break;
        end
        chk("wd_gap", cyc - s_cyc, START_TO + 1);
        chk("wd_retry", retry, 1);
        chk("wd_restrobe", tx_wr, 1);
        chk("wd_data", tx_data, 8'h3C);
        chk("wd_count", count, 0);
        @(negedge clk);
        chk("wd_retry_pulse", retry, 0);
        ti_hold = 1'b0;
        repeat (5) @(negedge clk);
        chk("wd_in_frame", busy, 1);
        ti_hold = 1'b1;
        repeat (3) @(negedge clk);
        chk("wd_done", busy, 0);
`endif

        // Reset in the middle of a frame with three bytes queued
        model_en = 1'b0; ti_hold = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hD0 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("mr_count4", count, 4);
        start_dly = 1; frame_len = 200;
        #1 model_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("mr_pre_count", count, 3);
        chk("mr_pre_busy", busy, 1);
        chk("mr_pre_ti", tx_ti, 0);
        #3 rst = 1'b1;
        #1;
        chk("mr_count", count, 0);
        chk("mr_empty", empty, 1);
        chk("mr_full", full, 0);
        chk("mr_tx_wr", tx_wr, 0);
        chk("mr_tx_data", tx_data, 8'h00);
        chk("mr_busy", busy, 0);
        chk("mr_ovf", overflow, 0);
        model_en = 1'b0; ti_hold = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_after_busy", busy, 0);
        chk("mr_after_count", count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte FIFO and handshake controller sitting directly upstream of the UART transmitter stage. Accepts bytes from a host-side write port and buffers them. Issues one single-cycle write strobe per byte to the transmitter, then tracks the transmitter's interrupt/idle flag (TI) so that it never strobes mid-frame. Lets software burst up to DEPTH bytes without polling TI.

Parameters:
- DEPTH, 16, FIFO depth in bytes; must be a power of two, 2..256.
- ADDR_W, 4, log2(DEPTH).
- START_TO, 12000, watchdog limit in clk cycles for TI to fall after a strobe; used only with the optional feature. Must exceed 2 bit periods, i.e. 2*5208 at 50 MHz/9600.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  host write strobe; one byte per cycle
- wr_data  in  8  host byte
- ovf_clr  in  1  clears the overflow flag
- full  out  1  FIFO holds DEPTH bytes
- empty  out  1  FIFO holds 0 bytes
- count  out  ADDR_W+1  current FIFO occupancy
- overflow  out  1  sticky flag: a write was dropped
- tx_ti  in  1  TI from the transmitter; 1 = idle/frame done, 0 = sending
- tx_wr  out  1  one-cycle write strobe to the transmitter
- tx_data  out  8  byte to the transmitter; stable from the tx_wr cycle until the next tx_wr
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: full=0, empty=1, count=0, overflow=0, tx_wr=0, tx_data=8'h00, busy=0, state=IDLE, both FIFO pointers 0.
- Reset mid-frame: the FIFO is discarded and the block returns to IDLE. There is no attempt to complete the frame.
- FIFO write: a write is accepted when wr_en=1 and count<DEPTH. It is stored at wr_ptr, wr_ptr increments modulo DEPTH, and count increments.
- Overflow: wr_en=1 while full drops the byte and sets overflow.
- Overflow clear: ovf_clr=1 clears overflow. If a drop occurs in the same cycle, the set wins.
- FIFO pop: a pop happens only on the IDLE->STROBE transition. rd_ptr increments modulo DEPTH and count decrements.
- Simultaneous write and pop: count is unchanged and both pointers advance.
- Status flags: full and empty are derived from count and are registered, so they change together with count.
- FSM state IDLE: if !empty and tx_ti=1, pop the head into tx_data and go to STROBE. Otherwise stay.
- FSM state STROBE: tx_wr=1 for exactly this cycle, then go to WAIT_START.
- FSM state WAIT_START: wait for tx_ti=0, meaning the transmitter has begun the frame (this can take up to one bit period), then go to WAIT_DONE. tx_wr=0.
- FSM state WAIT_DONE: wait for tx_ti=1, meaning the stop bit has finished, then go to IDLE.
- Back-to-back frames: the next byte is strobed no earlier than one cycle after IDLE is re-entered.
- Latency: with an empty FIFO in IDLE and tx_ti=1, a write at edge N updates count at N+1. tx_wr=1 with valid tx_data is seen in cycle N+2, and count returns to 0 at N+2.
- No fresh strobe in WAIT_START or WAIT_DONE: tx_ti rising during WAIT_START is ignored; only the 1->0 edge matters there.
- Writes while busy: host writes continue to be accepted in every state.
- Width rule: count is ADDR_W+1 bits, so DEPTH is representable. Pointers are ADDR_W bits and wrap naturally.

Optional Feature:
- Macro: UART_TX_FEEDER_WDOG_EN.
- With the macro defined: a 16-bit counter runs in WAIT_START.
  - If it reaches START_TO-1 without tx_ti falling, the FSM returns to STROBE and re-strobes the same tx_data. No pop occurs.
  - An extra output port, retry (1 bit, reset 0), pulses high for one cycle on each re-strobe.
  - The counter clears on leaving WAIT_START.
- Without the macro: no counter and no retry port. WAIT_START waits indefinitely.

Test Plan:
- Reset behaviour: assert rst mid-WAIT_DONE with count=3 -> all outputs return to reset values asynchronously (count=0, empty=1, tx_wr=0) and the FSM is in IDLE.
- Single byte: write 8'hA5 with tx_ti=1 -> in the second cycle after the write, tx_wr=1 for one cycle with tx_data=8'hA5. Then model tx_ti low for 10*5208 cycles and high again -> busy falls one cycle after tx_ti rises.
- Burst: write 8'h01..8'h05 in consecutive cycles while the transmitter model is busy -> count peaks at 5, then exactly 5 strobes with data 01,02,03,04,05 in order, each strobe only after tx_ti has gone 1->0->1.
- Overflow: write 17 bytes to an idle FIFO with tx_ti held 0 -> full=1 at count=16 and the 17th byte sets overflow. ovf_clr clears overflow, full stays 1, and the 17th byte is never transmitted.
- Wrap and simultaneous events: stream 40 bytes with a write landing in the same cycle as each pop -> pointers wrap twice, count stays consistent, and all 40 bytes leave the block in order.
- Watchdog (UART_TX_FEEDER_WDOG_EN): strobe 8'h3C with tx_ti held 1 -> after START_TO cycles, retry pulses and tx_wr re-fires with 8'h3C while count is unchanged. Then drop tx_ti -> normal completion.
